// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: payload + control with valid/ready,
// synchronous flush and an optional 2-entry skid buffer.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-low reset
//   in_valid   upstream entry valid
//   in_ready   entry accepted this cycle when in_valid is also high
//   in_data    upstream payload (DATA_W)
//   in_ctrl    upstream control field (CTRL_W)
//   flush      squash every held entry and any incoming one
//   out_valid  downstream entry valid
//   out_ready  downstream accepts
//   out_data   registered payload
//   out_ctrl   registered control, zero in every bubble
//   occupancy  held entries: 0, 1 or 2
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    // The state value doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_ready_q, in_ready_d;

    logic in_fire;
    logic out_fire;

    // Registered in_ready with the skid buffer; otherwise the single
    // register accepts whenever it is empty or draining this cycle.
    assign in_ready  = (SKID != 0) ? in_ready_q
                                   : (out_ready | ~out_valid);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign occupancy = state_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (flush) begin
            // Payload is left alone; only control is cleared so the
            // squashed slots become harmless bubbles.
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        state_d     = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (in_fire && (SKID != 0)) begin
                        // Downstream stalled: park the new entry.
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                        state_d     = ST_SKID;
                    end else if (out_fire) begin
                        main_ctrl_d = '0;
                        state_d     = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        skid_ctrl_d = '0;
                        state_d     = ST_FULL;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_ctrl_d = '0;
                    skid_ctrl_d = '0;
                end
            endcase
        end

        // Room exists exactly when the skid slot will be free.
        in_ready_d = (state_d != ST_SKID);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (SKID=1 and SKID=0).
// Inputs change #1 after the rising edge; outputs are checked there too.
module tb_pipe_stage_reg;

    logic        clock;
    logic        reset;

    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [7:0]  in_ctrl, out_ctrl;
    logic [1:0]  occupancy;

    logic        z_in_valid, z_in_ready, z_flush, z_out_valid, z_out_ready;
    logic [31:0] z_in_data, z_out_data;
    logic [7:0]  z_in_ctrl, z_out_ctrl;
    logic [1:0]  z_occupancy;

    int total = 0;
    int bad   = 0;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0)) dut0 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (z_in_valid),
        .in_ready  (z_in_ready),
        .in_data   (z_in_data),
        .in_ctrl   (z_in_ctrl),
        .flush     (z_flush),
        .out_valid (z_out_valid),
        .out_ready (z_out_ready),
        .out_data  (z_out_data),
        .out_ctrl  (z_out_ctrl),
        .occupancy (z_occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset       = 1'b0;
        in_valid    = 1'b1;
        in_data     = 32'h1234_5678;
        in_ctrl     = 8'hFF;
        flush       = 1'b0;
        out_ready   = 1'b1;
        z_in_valid  = 1'b0;
        z_in_data   = '0;
        z_in_ctrl   = '0;
        z_flush     = 1'b0;
        z_out_ready = 1'b0;

        // Reset held two cycles with junk on the input
        step();
        step();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ctrl",  {24'd0, out_ctrl},  32'd0);
        chk("rst_data",  out_data,           32'd0);
        chk("rst_occ",   {30'd0, occupancy}, 32'd0);
        chk("rst_ready", {31'd0, in_ready},  32'd1);
        chk("rst0_valid", {31'd0, z_out_valid}, 32'd0);

        reset    = 1'b1;
        in_valid = 1'b0;
        step();

        // Streaming, back to back
        in_valid = 1'b1;
        in_ctrl  = 8'h01;
        in_data  = 32'h0040_0000;
        step();
        chk("str0_data",  out_data, 32'h0040_0000);
        chk("str0_valid", {31'd0, out_valid}, 32'd1);
        in_data = 32'h0040_0004;
        step();
        chk("str1_data",  out_data, 32'h0040_0004);
        chk("str1_valid", {31'd0, out_valid}, 32'd1);
        in_data = 32'h0040_0008;
        step();
        chk("str2_data",  out_data, 32'h0040_0008);
        chk("str2_valid", {31'd0, out_valid}, 32'd1);
        chk("str2_ctrl",  {24'd0, out_ctrl}, 32'h01);
        in_valid = 1'b0;
        step();
        chk("str_drain_valid", {31'd0, out_valid}, 32'd0);
        chk("str_drain_ctrl",  {24'd0, out_ctrl},  32'd0);
        chk("str_drain_occ",   {30'd0, occupancy}, 32'd0);

        // Stall into the skid slot
        in_valid = 1'b1;
        in_data  = 32'hA;
        in_ctrl  = 8'h11;
        step();
        chk("stall_occ1", {30'd0, occupancy}, 32'd1);
        out_ready = 1'b0;
        in_data   = 32'hB;
        in_ctrl   = 8'h22;
        step();
        chk("stall_occ2",  {30'd0, occupancy}, 32'd2);
        chk("stall_ready", {31'd0, in_ready},  32'd0);
        chk("stall_data",  out_data, 32'hA);
        chk("stall_ctrl",  {24'd0, out_ctrl}, 32'h11);
        in_valid = 1'b0;
        step();
        chk("stall_hold_data", out_data, 32'hA);
        chk("stall_hold_occ",  {30'd0, occupancy}, 32'd2);
        out_ready = 1'b1;
        #1;
        chk("drain_first", out_data, 32'hA);
        step();
        chk("drain_second", out_data, 32'hB);
        chk("drain_ctrl",   {24'd0, out_ctrl}, 32'h22);
        chk("drain_ready",  {31'd0, in_ready}, 32'd1);
        chk("drain_occ",    {30'd0, occupancy}, 32'd1);
        step();
        chk("drain_empty", {31'd0, out_valid}, 32'd0);

        // Flush with both slots full and C waiting
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_data   = 32'h1;
        in_ctrl   = 8'h33;
        step();
        in_data = 32'h2;
        step();
        chk("fl_pre_occ", {30'd0, occupancy}, 32'd2);
        in_data = 32'hC;
        in_ctrl = 8'h44;
        flush   = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_ctrl",  {24'd0, out_ctrl},  32'd0);
        chk("fl_occ",   {30'd0, occupancy}, 32'd0);
        chk("fl_ready", {31'd0, in_ready},  32'd1);
        chk("fl_data_hold", out_data, 32'h1);
        out_ready = 1'b1;
        step();
        chk("fl_no_c_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_no_c_data",  out_data, 32'h1);

        // Flush discards a same-cycle accept from empty
        in_valid = 1'b1;
        in_data  = 32'hD;
        in_ctrl  = 8'h66;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_in_occ",  {30'd0, occupancy}, 32'd0);
        chk("fl_in_ctrl", {24'd0, out_ctrl},  32'd0);

        // Reset beats flush while holding two entries
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_data   = 32'h5;
        in_ctrl   = 8'h77;
        step();
        in_data = 32'h6;
        step();
        chk("rm_pre_occ", {30'd0, occupancy}, 32'd2);
        flush   = 1'b1;
        reset   = 1'b0;
        in_ctrl = 8'hFF;
        step();
        chk("rm_valid", {31'd0, out_valid}, 32'd0);
        chk("rm_ctrl",  {24'd0, out_ctrl},  32'd0);
        chk("rm_data",  out_data,           32'd0);
        chk("rm_occ",   {30'd0, occupancy}, 32'd0);
        chk("rm_ready", {31'd0, in_ready},  32'd1);
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        in_data   = 32'h77;
        in_ctrl   = 8'h55;
        step();
        in_valid = 1'b0;
        chk("rm_push_valid", {31'd0, out_valid}, 32'd1);
        chk("rm_push_data",  out_data, 32'h77);
        chk("rm_push_ctrl",  {24'd0, out_ctrl}, 32'h55);
        step();

        // SKID=0: combinational in_ready, single register
        z_in_valid  = 1'b1;
        z_in_data   = 32'h100;
        z_in_ctrl   = 8'h0A;
        z_out_ready = 1'b0;
        #1;
        chk("z_empty_ready", {31'd0, z_in_ready}, 32'd1);
        step();
        chk("z_full_valid", {31'd0, z_out_valid}, 32'd1);
        chk("z_full_data",  z_out_data, 32'h100);
        z_in_data = 32'h104;
        z_in_ctrl = 8'h0B;
        #1;
        chk("z_stall_ready", {31'd0, z_in_ready}, 32'd0);
        step();
        chk("z_stall_data", z_out_data, 32'h100);
        chk("z_stall_occ",  {30'd0, z_occupancy}, 32'd1);
        z_out_ready = 1'b1;
        #1;
        chk("z_comb_ready", {31'd0, z_in_ready}, 32'd1);
        step();
        chk("z_swap_data", z_out_data, 32'h104);
        chk("z_swap_ctrl", {24'd0, z_out_ctrl}, 32'h0B);
        chk("z_swap_occ",  {30'd0, z_occupancy}, 32'd1);
        z_in_valid = 1'b0;
        step();
        chk("z_drain_valid", {31'd0, z_out_valid}, 32'd0);
        chk("z_drain_ctrl",  {24'd0, z_out_ctrl},  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic pipeline-stage register for the MIPS32 datapath (IF/ID, ID/EX, EX/MEM and MEM/WB boundaries).
- Replaces fixed per-stage latch modules with one block that carries a generic payload plus a control field.
- Adds a valid/ready handshake for stall back-pressure, a synchronous flush for branch/jump squash, and an optional 2-entry skid buffer so in_ready is registered.
- Bubbles always carry all-zero control, so a squashed or empty slot never writes the register file or memory.

Parameters:
- DATA_W, 32: width of the payload (PC, IR, ALU result, memory data, etc. concatenated by the instantiating stage).
- CTRL_W, 8: width of the control field (reg_write, mem_to_reg, pc_to_reg, write_addr, ...); forced to zero in bubbles.
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  upstream stage presents a valid instruction
- in_ready  out  1  block accepts this cycle; in_fire = in_valid & in_ready
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control field
- flush  in  1  synchronous squash of all held and incoming entries
- out_valid  out  1  downstream payload valid
- out_ready  in  1  downstream accepts; out_fire = out_valid & out_ready
- out_data  out  DATA_W  registered payload
- out_ctrl  out  CTRL_W  registered control field; zero whenever out_valid = 0
- occupancy  out  2  number of held entries: 0, 1 or 2

Behaviour:
- Reset: reset is synchronous and active-low; clock is clock. When reset = 0 at a rising edge, the following values apply from the next cycle:
  - out_valid = 0, out_data = 0, out_ctrl = 0, occupancy = 0
  - skid entry invalid, with zero data and zero control
  - SKID = 1: in_ready = 1
- Reset takes priority over flush and all handshakes, including reset asserted while the block is FULL or SKID.
- Priority order at each edge: reset, then flush, then handshake.
- Flush:
  - At the edge, both entries are invalidated: out_valid = 0, out_ctrl = 0, skid invalid, occupancy = 0.
  - An in_fire in the same cycle is discarded.
  - out_data holds its previous value.
  - In SKID = 1, in_ready = 1 on the next cycle.
- Latency and throughput: 1 cycle from in_fire to out_valid. Throughput is 1 transfer per cycle with no bubbles while out_ready = 1.
- Stability: while out_valid = 1 and out_ready = 0, out_data and out_ctrl do not change.
- Ordering: transfers leave in the order they were accepted. No loss and no duplication except on flush or reset.
- SKID = 1 state machine (state is encoded by occupancy):
  - EMPTY (occupancy 0): in_ready = 1.
    - in_fire: main <= in, go to FULL.
  - FULL (occupancy 1): in_ready = 1.
    - in_fire & out_fire: main <= in, stay in FULL.
    - in_fire & !out_fire: skid <= in, go to SKID.
    - !in_fire & out_fire: go to EMPTY; out_ctrl <= 0.
    - neither: hold.
  - SKID (occupancy 2): in_ready = 0.
    - out_fire: main <= skid, skid invalid, go to FULL.
    - otherwise: hold.
  - in_ready is a flop output: 1 exactly when the skid entry is invalid.
- SKID = 0:
  - Single register (states EMPTY/FULL).
  - in_ready = out_ready | ~out_valid, combinationally.
  - in_fire loads main; out_fire without in_fire empties it and zeroes out_ctrl.
  - occupancy never exceeds 1.
- Bubbles: any edge that leaves out_valid = 0 also sets out_ctrl = 0. out_data in a bubble is don't-care but holds its previous value.
- Ignored inputs: in_data and in_ctrl are ignored when in_fire = 0.

Test Plan:
- Reset: drive reset = 0 for 2 cycles with in_valid = 1 and in_ctrl = 8'hFF.
  - Required: out_valid = 0, out_ctrl = 0, out_data = 0, occupancy = 0, in_ready = 1.
- Streaming: out_ready = 1, push in_data = 0x00400000, 0x00400004, 0x00400008 on consecutive cycles.
  - Required: each appears on out_data one cycle later, back to back, out_valid = 1 throughout.
- Stall (SKID = 1): push A = 0xA, then hold out_ready = 0 and push B = 0xB.
  - Required: occupancy 2, in_ready = 0, out_data stable at 0xA.
  - Then raise out_ready: 0xA, then 0xB, drain in order; in_ready returns to 1 one cycle after the first out_fire.
- Flush: with occupancy 2 and in_valid = 1 (C = 0xC), pulse flush for one cycle.
  - Required next cycle: out_valid = 0, out_ctrl = 0, occupancy = 0; 0xC never appears on the output.
- Reset mid-operation: occupancy 2 with flush = 1, then reset = 0 in the same cycle.
  - Required: the reset state exactly as in the reset scenario; the first push after reset release emerges after 1 cycle.
- SKID = 0 build: out_ready = 0 with the register FULL.
  - Required: in_ready = 0 in the same cycle.
  - Then out_ready = 1 with in_valid = 1: in_ready = 1 combinationally, and a new entry is accepted while the old one drains.
